// File: rtl/sprite_layer_pipe.sv
// rtl/sprite_layer_pipe.sv - pipelined multi-layer 4x4 block sprite address resolver
module sprite_layer_pipe #(
    parameter int NUM_BLOCKS   = 2,
    parameter int TILE         = 20,
    parameter int GRID         = 4,
    parameter int ADDR_W       = 16,
    parameter int BG_SPRITE    = 37,
    parameter int RAM_LATENCY  = 1,
    parameter int FLASH_FRAMES = 16,
    localparam int HC_W        = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1
) (
    input  logic                            Clk,
    input  logic                            Reset_n,
    input  logic                            pix_valid,
    input  logic [9:0]                      DrawX,
    input  logic [9:0]                      DrawY,
    input  logic                            frame_start,
    input  logic [10*NUM_BLOCKS-1:0]        PosX,
    input  logic [10*NUM_BLOCKS-1:0]        PosY,
    input  logic [GRID*GRID*NUM_BLOCKS-1:0] blockstate,
    input  logic [6*NUM_BLOCKS-1:0]         spriteindex,
    input  logic [2*NUM_BLOCKS-1:0]         mode,
    output logic [ADDR_W-1:0]               sprite_addr,
    output logic                            addr_valid,
    input  logic [3:0]                      ram_data,
    output logic [3:0]                      colorindex_draw,
    output logic                            draw_valid,
    output logic                            draw_hit,
    output logic [HC_W-1:0]                 hit_channel
);

    localparam int BOX   = GRID * TILE;
    localparam int GG    = GRID * GRID;
    localparam int GW    = $clog2(GG);
    localparam int TW    = $clog2(TILE);
    localparam int CNT_W = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;

    localparam logic [1:0] MODE_OFF   = 2'd0;
    localparam logic [1:0] MODE_SOLID = 2'd1;
    localparam logic [1:0] MODE_GHOST = 2'd2;

    // flash phase state
    logic [CNT_W-1:0] r_frame_cnt;
    logic             r_flash_phase;

    // per-channel combinational geometry, evaluated on the incoming pixel
    logic [10:0]      w_rx     [NUM_BLOCKS];
    logic [10:0]      w_ry     [NUM_BLOCKS];
    logic [9:0]       w_col    [NUM_BLOCKS];
    logic [9:0]       w_row    [NUM_BLOCKS];
    logic [TW-1:0]    w_tx     [NUM_BLOCKS];
    logic [TW-1:0]    w_ty     [NUM_BLOCKS];
    logic [GG-1:0]    w_bs_ch  [NUM_BLOCKS];
    logic [GW-1:0]    w_idx    [NUM_BLOCKS];
    logic [NUM_BLOCKS-1:0] w_inbox;
    logic [NUM_BLOCKS-1:0] w_occ;
    logic [NUM_BLOCKS-1:0] w_edge;
    logic [NUM_BLOCKS-1:0] w_hit;

    // stage 1 registers
    logic                  r_s1_valid;
    logic [NUM_BLOCKS-1:0] r_s1_hit;
    logic [TW-1:0]         r_s1_tx  [NUM_BLOCKS];
    logic [TW-1:0]         r_s1_ty  [NUM_BLOCKS];
    logic [5:0]            r_s1_spr [NUM_BLOCKS];
    logic [TW-1:0]         r_s1_mx;
    logic [TW-1:0]         r_s1_my;

    // stage 2 winner selection
    logic              w_win_hit;
    logic [HC_W-1:0]   w_win_ch;
    logic [TW-1:0]     w_win_tx;
    logic [TW-1:0]     w_win_ty;
    logic [5:0]        w_win_spr;
    logic [ADDR_W-1:0] w_addr;

    logic              r_s2_hit;
    logic [HC_W-1:0]   r_s2_ch;

    // RAM latency alignment
    logic              r_dl_valid [RAM_LATENCY];
    logic              r_dl_hit   [RAM_LATENCY];
    logic [HC_W-1:0]   r_dl_ch    [RAM_LATENCY];

    // frame counter: toggles the flash phase every FLASH_FRAMES frame_start pulses
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_frame_cnt   <= '0;
            r_flash_phase <= 1'b1;
        end else if (frame_start) begin
            if (r_frame_cnt == CNT_W'(FLASH_FRAMES - 1)) begin
                r_frame_cnt   <= '0;
                r_flash_phase <= ~r_flash_phase;
            end else begin
                r_frame_cnt <= r_frame_cnt + 1'b1;
            end
        end
    end

    // per-channel box test, tile decode and mode-qualified hit; the flash phase
    // seen here is the pre-update value, so a coincident frame_start does not affect this pixel
    always_comb begin
        for (int i = 0; i < NUM_BLOCKS; i++) begin
            w_rx[i]    = {1'b0, DrawX} - {1'b0, PosX[10*i +: 10]};
            w_ry[i]    = {1'b0, DrawY} - {1'b0, PosY[10*i +: 10]};
            w_inbox[i] = !w_rx[i][10] && (w_rx[i] < 11'(BOX)) &&
                         !w_ry[i][10] && (w_ry[i] < 11'(BOX));
            w_col[i]   = w_rx[i][9:0] / 10'(TILE);
            w_row[i]   = w_ry[i][9:0] / 10'(TILE);
            w_tx[i]    = TW'(w_rx[i][9:0] % 10'(TILE));
            w_ty[i]    = TW'(w_ry[i][9:0] % 10'(TILE));
            w_bs_ch[i] = blockstate[GG*i +: GG];
            w_idx[i]   = GW'(w_row[i] * 10'(GRID) + w_col[i]);
            w_occ[i]   = w_inbox[i] && w_bs_ch[i][w_idx[i]];
            w_edge[i]  = (w_tx[i] == '0) || (w_tx[i] == TW'(TILE - 1)) ||
                         (w_ty[i] == '0) || (w_ty[i] == TW'(TILE - 1));
            case (mode[2*i +: 2])
                MODE_OFF:   w_hit[i] = 1'b0;
                MODE_SOLID: w_hit[i] = w_occ[i];
                MODE_GHOST: w_hit[i] = w_occ[i] && w_edge[i];
                default:    w_hit[i] = w_occ[i] && r_flash_phase;
            endcase
        end
    end

    // stage 1: capture per-channel hit, local tile offsets and sprite, plus screen tile offsets
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_s1_valid <= 1'b0;
            r_s1_hit   <= '0;
            r_s1_mx    <= '0;
            r_s1_my    <= '0;
            for (int i = 0; i < NUM_BLOCKS; i++) begin
                r_s1_tx[i]  <= '0;
                r_s1_ty[i]  <= '0;
                r_s1_spr[i] <= '0;
            end
        end else begin
            r_s1_valid <= pix_valid;
            r_s1_hit   <= w_hit;
            r_s1_mx    <= TW'(DrawX % 10'(TILE));
            r_s1_my    <= TW'(DrawY % 10'(TILE));
            for (int i = 0; i < NUM_BLOCKS; i++) begin
                r_s1_tx[i]  <= w_tx[i];
                r_s1_ty[i]  <= w_ty[i];
                r_s1_spr[i] <= spriteindex[6*i +: 6];
            end
        end
    end

    // lowest-index hitting channel wins; background tile otherwise
    always_comb begin
        w_win_hit = 1'b0;
        w_win_ch  = '0;
        w_win_tx  = '0;
        w_win_ty  = '0;
        w_win_spr = '0;
        for (int i = NUM_BLOCKS - 1; i >= 0; i--) begin
            if (r_s1_hit[i]) begin
                w_win_hit = 1'b1;
                w_win_ch  = HC_W'(i);
                w_win_tx  = r_s1_tx[i];
                w_win_ty  = r_s1_ty[i];
                w_win_spr = r_s1_spr[i];
            end
        end
        if (w_win_hit) begin
            w_addr = ADDR_W'(w_win_spr) * ADDR_W'(TILE * TILE) +
                     ADDR_W'(w_win_ty) * ADDR_W'(TILE) + ADDR_W'(w_win_tx);
        end else begin
            w_addr = ADDR_W'(BG_SPRITE * TILE * TILE) +
                     ADDR_W'(r_s1_my) * ADDR_W'(TILE) + ADDR_W'(r_s1_mx);
        end
    end

    // stage 2: registered sprite RAM address and hit info; bubbles never report a hit
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            sprite_addr <= '0;
            addr_valid  <= 1'b0;
            r_s2_hit    <= 1'b0;
            r_s2_ch     <= '0;
        end else begin
            sprite_addr <= w_addr;
            addr_valid  <= r_s1_valid;
            r_s2_hit    <= r_s1_valid && w_win_hit;
            r_s2_ch     <= (r_s1_valid && w_win_hit) ? w_win_ch : '0;
        end
    end

    // delay line matching the sprite RAM read latency
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int k = 0; k < RAM_LATENCY; k++) begin
                r_dl_valid[k] <= 1'b0;
                r_dl_hit[k]   <= 1'b0;
                r_dl_ch[k]    <= '0;
            end
        end else begin
            r_dl_valid[0] <= addr_valid;
            r_dl_hit[0]   <= r_s2_hit;
            r_dl_ch[0]    <= r_s2_ch;
            for (int k = 1; k < RAM_LATENCY; k++) begin
                r_dl_valid[k] <= r_dl_valid[k-1];
                r_dl_hit[k]   <= r_dl_hit[k-1];
                r_dl_ch[k]    <= r_dl_ch[k-1];
            end
        end
    end

    // output stage: returned colour index realigned with its hit information
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            colorindex_draw <= '0;
            draw_valid      <= 1'b0;
            draw_hit        <= 1'b0;
            hit_channel     <= '0;
        end else begin
            colorindex_draw <= ram_data;
            draw_valid      <= r_dl_valid[RAM_LATENCY-1];
            draw_hit        <= r_dl_valid[RAM_LATENCY-1] && r_dl_hit[RAM_LATENCY-1];
            hit_channel     <= r_dl_ch[RAM_LATENCY-1];
        end
    end

endmodule

// File: tb/tb_sprite_layer_pipe.sv
// tb/tb_sprite_layer_pipe.sv - scoreboard testbench for sprite_layer_pipe
module tb_sprite_layer_pipe;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        pix_valid;
    logic [9:0]  DrawX, DrawY;
    logic        frame_start;
    logic [19:0] PosX, PosY;
    logic [31:0] blockstate;
    logic [11:0] spriteindex;
    logic [3:0]  mode;
    logic [15:0] sprite_addr;
    logic        addr_valid;
    logic [3:0]  ram_data;
    logic [3:0]  colorindex_draw;
    logic        draw_valid, draw_hit;
    logic        hit_channel;

    logic [9:0]  px [2];
    logic [9:0]  py [2];
    logic [15:0] bs [2];
    logic [5:0]  sp [2];
    logic [1:0]  md [2];

    assign PosX        = {px[1], px[0]};
    assign PosY        = {py[1], py[0]};
    assign blockstate  = {bs[1], bs[0]};
    assign spriteindex = {sp[1], sp[0]};
    assign mode        = {md[1], md[0]};

    sprite_layer_pipe #(.NUM_BLOCKS(2), .FLASH_FRAMES(2)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .pix_valid(pix_valid),
        .DrawX(DrawX), .DrawY(DrawY), .frame_start(frame_start),
        .PosX(PosX), .PosY(PosY), .blockstate(blockstate),
        .spriteindex(spriteindex), .mode(mode),
        .sprite_addr(sprite_addr), .addr_valid(addr_valid), .ram_data(ram_data),
        .colorindex_draw(colorindex_draw), .draw_valid(draw_valid),
        .draw_hit(draw_hit), .hit_channel(hit_channel)
    );

    always #5 Clk = ~Clk;

    function automatic logic [3:0] ram_fn(input logic [15:0] a);
        return a[3:0] ^ a[7:4] ^ a[11:8] ^ a[15:12];
    endfunction

    // one-cycle-latency sprite RAM model
    always @(posedge Clk) ram_data <= ram_fn(sprite_addr);

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [15:0] addr;
        logic        hit;
        logic        ch;
        logic [31:0] t;
    } exp_t;

    exp_t q_a[$];
    exp_t q_d[$];
    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // monitor: pops the scoreboard whenever the DUT presents an address or a draw output
    always @(negedge Clk) begin : monitor
        exp_t e;
        if (addr_valid) begin
            if (q_a.size() == 0) begin
                chk("unexpected_addr_valid", 1, 0);
            end else begin
                e = q_a.pop_front();
                chk("sprite_addr", 32'(sprite_addr), 32'(e.addr));
                chk("addr_latency", cyc, e.t + 2);
            end
        end
        if (draw_valid) begin
            if (q_d.size() == 0) begin
                chk("unexpected_draw_valid", 1, 0);
            end else begin
                e = q_d.pop_front();
                chk("colorindex_draw", 32'(colorindex_draw), 32'(ram_fn(e.addr)));
                chk("draw_hit", 32'(draw_hit), 32'(e.hit));
                chk("hit_channel", 32'(hit_channel), 32'(e.ch));
                chk("draw_latency", cyc, e.t + 4);
            end
        end
    end

    task automatic tick();
        @(negedge Clk);
        pix_valid   = 1'b0;
        frame_start = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic put(input logic [9:0] x, input logic [9:0] y,
                       input logic [15:0] a, input logic h, input logic c);
        DrawX     = x;
        DrawY     = y;
        pix_valid = 1'b1;
        q_a.push_back('{addr: a, hit: h, ch: c, t: cyc});
        q_d.push_back('{addr: a, hit: h, ch: c, t: cyc});
    endtask

    task automatic cfg(input int c, input logic [9:0] x, input logic [9:0] y,
                       input logic [15:0] b, input logic [5:0] s, input logic [1:0] m);
        px[c] = x; py[c] = y; bs[c] = b; sp[c] = s; md[c] = m;
    endtask

    task automatic pulse();
        tick();
        frame_start = 1'b1;
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_sprite_addr"}, 32'(sprite_addr), 0);
        chk({tag, "_addr_valid"}, 32'(addr_valid), 0);
        chk({tag, "_colorindex"}, 32'(colorindex_draw), 0);
        chk({tag, "_draw_valid"}, 32'(draw_valid), 0);
        chk({tag, "_draw_hit"}, 32'(draw_hit), 0);
        chk({tag, "_hit_channel"}, 32'(hit_channel), 0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog timeout actual=running expected=finished");
        $fatal(1);
    end

    initial begin
        Reset_n = 1'b0; pix_valid = 1'b0; frame_start = 1'b0;
        DrawX = '0; DrawY = '0;
        cfg(0, 0, 0, 0, 0, 0);
        cfg(1, 0, 0, 0, 0, 0);
        idle(3);
        chk_outputs_zero("reset");
        Reset_n = 1'b1;
        idle(2);

        // solid hit and background
        tick(); cfg(0, 100, 40, 16'h0001, 3, 1); put(105, 47, 1345, 1, 0);
        tick(); cfg(0, 100, 40, 16'h0000, 3, 1); put(105, 47, 14945, 0, 0);
        // priority, then ch0 switched off on the very next pixel
        tick(); cfg(0, 100, 40, 16'h0001, 3, 1); cfg(1, 100, 40, 16'h0001, 5, 1);
                put(105, 47, 1345, 1, 0);
        tick(); cfg(0, 100, 40, 16'h0001, 3, 0); put(105, 47, 2145, 1, 1);
        tick(); cfg(1, 100, 40, 16'h0001, 5, 0);
        // ghost outline
        cfg(0, 100, 40, 16'h0001, 3, 2); put(105, 47, 14945, 0, 0);
        tick(); put(100, 47, 1340, 1, 0);
        tick(); put(110, 40, 1210, 1, 0);
        // box edges and block indexing
        tick(); cfg(0, 100, 40, 16'h000F, 3, 1); put(99, 47, 14959, 0, 0);
        tick(); put(180, 47, 14940, 0, 0);
        tick(); put(179, 47, 1359, 1, 0);
        tick(); cfg(0, 100, 40, 16'h0020, 3, 1); put(125, 61, 1225, 1, 0);
        tick(); cfg(0, 1015, 40, 16'hFFFF, 3, 1); put(5, 47, 14945, 0, 0);
        idle(6);

        // flash: phase toggles every 2 pulses; coincident pulse uses old phase
        tick(); cfg(0, 100, 40, 16'h0001, 3, 3); put(105, 47, 1345, 1, 0);
        pulse(); pulse();
        tick(); put(105, 47, 14945, 0, 0);
        pulse();
        tick(); put(105, 47, 14945, 0, 0); frame_start = 1'b1;
        tick(); put(105, 47, 1345, 1, 0);
        idle(6);

        // leave phase 0 / counter 1, then reset with pixels in flight
        pulse(); pulse(); pulse();
        tick(); put(105, 47, 14945, 0, 0);
        tick(); put(106, 47, 14946, 0, 0);
        tick(); put(107, 47, 14947, 0, 0);
        tick(); put(108, 47, 14948, 0, 0);
        #2;
        Reset_n = 1'b0;
        pix_valid = 1'b0;
        #1;
        chk_outputs_zero("midreset");
        q_a.delete();
        q_d.delete();
        idle(3);
        Reset_n = 1'b1;
        idle(8);

        // phase back to visible and counter cleared: one pulse must not toggle
        tick(); put(105, 47, 1345, 1, 0);
        pulse();
        tick(); put(105, 47, 1345, 1, 0);
        idle(8);

        chk("addr_queue_drained", 32'(q_a.size()), 0);
        chk("draw_queue_drained", 32'(q_d.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
